// File: rtl/mem_datos_arb.sv
`timescale 1ns/1ps
// mem_datos_arb
// Two-port round-robin arbiter and access sequencer that sits in front of the
// word-addressed data memory. Each granted access runs through
// IDLE -> SETUP -> STROBE -> DONE. The address and data are stable through
// SETUP. The single active-low strobe is asserted only during STROBE. The
// requesting port sees a one-cycle ack during DONE.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req0/we0/addr0/wdata0 -> ack0   port 0 (CPU load/store path)
//   req1/we1/addr1/wdata1 -> ack1   port 1 (debug/loader path)
//   rdata               registered read data, valid while ack0/ack1 is high
//   busy                high whenever the sequencer is not idle
//   Mem_rd, Mem_wr      active-low memory strobes (registered, never both low)
//   Dir_Mem             memory address, held from grant to the next grant
//   Dato_Mem_in         memory write data, held from grant to the next grant
//   Dato_Mem_out        memory read data
//   err                 (MEM_DATOS_ARB_RANGE_EN only) pulses with the ack of an
//                       access whose address lies outside BASE..BASE+DEPTH-1
//
// Build option
//   MEM_DATOS_ARB_RANGE_EN  enables the address range check and the err port.
//   When this option is enabled, an out-of-range access still takes the full
//   four cycles. Its strobes stay high. A read returns 32'hDEADBEEF.
module mem_datos_arb #(
  parameter int            AW    = 32,
  parameter int            DW    = 32,
  parameter logic [AW-1:0] BASE  = AW'(32'h10000000),
  parameter int            DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          Mem_rd,
  output logic          Mem_wr,
  output logic [AW-1:0] Dir_Mem,
  output logic [DW-1:0] Dato_Mem_in,
  input  logic [DW-1:0] Dato_Mem_out
`ifdef MEM_DATOS_ARB_RANGE_EN
  ,
  output logic          err
`endif
);

`ifdef MEM_DATOS_ARB_RANGE_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif
  localparam logic [DW-1:0] BAD_DATA = DW'(32'hDEADBEEF);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

  state_t        state, state_next;
  logic          last, port_q, we_q, oor_q;
  logic          grant_valid, grant_port, grant_we, grant_oor;
  logic [AW-1:0] grant_addr;
  logic [DW-1:0] grant_wdata;
  logic          rd_next, wr_next, ack0_next, ack1_next;

  // Arbitration. A lone request wins outright. On a tie, the port that did not
  // win the previous tie is chosen. "last" starts at 1, so port 0 takes the
  // first tie. The range check uses an unsigned offset from BASE. That way, a
  // single compare also catches addresses below BASE.
  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) grant_port = ~last;
    else              grant_port = req1;
    grant_we    = grant_port ? we1    : we0;
    grant_addr  = grant_port ? addr1  : addr0;
    grant_wdata = grant_port ? wdata1 : wdata0;
    grant_oor   = RANGE_EN && ((grant_addr - BASE) >= AW'(DEPTH));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and next values of the registered pin outputs. The strobe for
  // STROBE is decided while in SETUP. The ack for DONE is decided while in
  // STROBE. As a result, every pin toggles straight from a flop, with no decode.
  always_comb begin
    state_next = state;
    rd_next    = 1'b1;
    wr_next    = 1'b1;
    ack0_next  = 1'b0;
    ack1_next  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) state_next = SETUP;
      end
      SETUP: begin
        state_next = STROBE;
        if (!oor_q) begin
          rd_next = we_q;
          wr_next = ~we_q;
        end
      end
      STROBE: begin
        state_next = DONE;
        ack0_next  = ~port_q;
        ack1_next  = port_q;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pin registers. The asynchronous reset releases a strobe that is in flight
  // right away. It also kills any ack that is pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Mem_rd <= 1'b1;
      Mem_wr <= 1'b1;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
    end else begin
      Mem_rd <= rd_next;
      Mem_wr <= wr_next;
      ack0   <= ack0_next;
      ack1   <= ack1_next;
    end
  end

  // Grant-time capture of the access, tie history, and read data return.
  // Dir_Mem/Dato_Mem_in keep their values from one grant until the next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Dir_Mem     <= '0;
      Dato_Mem_in <= '0;
      rdata       <= '0;
      we_q        <= 1'b0;
      port_q      <= 1'b0;
      oor_q       <= 1'b0;
      last        <= 1'b1;
    end else begin
      if (state == IDLE && grant_valid) begin
        Dir_Mem     <= grant_addr;
        Dato_Mem_in <= grant_wdata;
        we_q        <= grant_we;
        port_q      <= grant_port;
        oor_q       <= grant_oor;
        if (req0 && req1) last <= grant_port;
      end
      if (state == STROBE && !we_q) rdata <= oor_q ? BAD_DATA : Dato_Mem_out;
    end
  end

  assign busy = (state != IDLE);

`ifdef MEM_DATOS_ARB_RANGE_EN
  // err is registered alongside ack, so the two pulse in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else     err <= (state == STROBE) && oor_q;
  end
`endif

endmodule

// File: tb/tb_mem_datos_arb.sv
`timescale 1ns/1ps
// tb_mem_datos_arb
// Self-checking bench for mem_datos_arb. A small memory of four words responds
// to the strobes. The expected results come from a reference model of the
// memory contents, the last read value, and the tie history.
module tb_mem_datos_arb;

  localparam logic [31:0] BASE = 32'h10000000;
  localparam logic [31:0] DEAD = 32'hDEADBEEF;
`ifdef MEM_DATOS_ARB_RANGE_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1, ack0, ack1, busy, Mem_rd, Mem_wr, err_w;
  logic [31:0] addr0, wdata0, addr1, wdata1, rdata, Dir_Mem, Dato_Mem_in, Dato_Mem_out;

  mem_datos_arb dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .busy(busy), .Mem_rd(Mem_rd), .Mem_wr(Mem_wr),
    .Dir_Mem(Dir_Mem), .Dato_Mem_in(Dato_Mem_in), .Dato_Mem_out(Dato_Mem_out)
`ifdef MEM_DATOS_ARB_RANGE_EN
    , .err(err_w)
`endif
  );
`ifndef MEM_DATOS_ARB_RANGE_EN
  assign err_w = 1'b0;
`endif

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int both_low = 0;
  int ack_both = 0;

  // Memory model attached to the pins. Only the four words at BASE exist.
  // Reads elsewhere return 0. Writes elsewhere are ignored.
  logic [31:0] mem [4];
  function automatic bit in_rng(input logic [31:0] a);
    return (a - BASE) < 32'd4;
  endfunction
  assign Dato_Mem_out = in_rng(Dir_Mem) ? mem[Dir_Mem[1:0]] : 32'h0;
  always @(posedge clk) if (!Mem_wr && in_rng(Dir_Mem)) mem[Dir_Mem[1:0]] = Dato_Mem_in;

  // Protocol watch: the two strobes must never be low together, and the two acks
  // must never be high together.
  always @(negedge clk) begin
    if (!Mem_rd && !Mem_wr) both_low++;
    if (ack0 && ack1) ack_both++;
  end

  // Reference model: the memory contents, the last read data, and the winner of
  // the last tie.
  logic [31:0] ref_mem [4];
  logic [31:0] ref_rdata;
  bit          ref_last;

  task automatic ref_access(input bit w, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] exp_rd, output bit exp_err);
    bit ok;
    ok = in_rng(a);
    exp_err = RANGE_EN && !ok;
    if (w) begin
      if (ok) ref_mem[a[1:0]] = d;
    end else begin
      ref_rdata = ok ? ref_mem[a[1:0]] : (RANGE_EN ? DEAD : 32'h0);
    end
    exp_rd = ref_rdata;
  endtask

  task automatic ref_arbitrate(input bit r0, input bit r1, output bit winner);
    if (r0 && r1) begin
      winner   = ~ref_last;
      ref_last = winner;
    end else begin
      winner = r1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_port(input bit p, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    if (p) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
  endtask

  // Runs one access on a single port, starting from an idle cycle. It returns
  // the number of negedges until ack (-1 if ack never arrives), the rdata and
  // err seen at ack, and the number of cycles each strobe was low.
  task automatic applyStimulus(input bit p, input bit w, input logic [31:0] a, input logic [31:0] d,
                               output int lat, output logic [31:0] rd, output bit e,
                               output int nrd, output int nwr);
    bit got;
    @(negedge clk);
    drive_port(p, 1'b1, w, a, d);
    lat = 0; nrd = 0; nwr = 0; got = 1'b0; rd = '0; e = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (!Mem_rd) nrd++;
      if (!Mem_wr) nwr++;
      if (p ? ack1 : ack0) begin
        got = 1'b1;
        rd  = rdata;
        e   = err_w;
      end
    end
    drive_port(p, 1'b0, 1'b0, 32'h0, 32'h0);
    if (!got) lat = -1;
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int          lat, nrd, nwr, cyc, prev, n, t0, t1;
    logic [31:0] rd, erd, erd0, erd1;
    bit          e, eerr, w0, w1;
    bit          exp_port [4];
    logic [31:0] exp_rd [4];

    // The stimulus table. For each write, the expected rdata is the value left
    // by the read before it.
    vecs[0] = '{1'b1, 1'b1, BASE + 32'd1, 32'h000000AA, 32'h00000000};
    vecs[1] = '{1'b1, 1'b0, BASE + 32'd1, 32'h00000000, 32'h000000AA};
    vecs[2] = '{1'b0, 1'b0, BASE + 32'd2, 32'h00000000, 32'h0000000D};
    vecs[3] = '{1'b0, 1'b1, BASE + 32'd3, 32'h12345678, 32'h0000000D};
    vecs[4] = '{1'b1, 1'b0, BASE + 32'd3, 32'h00000000, 32'h12345678};
    vecs[5] = '{1'b0, 1'b0, BASE + 32'd0, 32'h00000000, 32'h11111111};

    rst = 1'b1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    mem[0] = 32'h11111111; mem[1] = 32'h22222222; mem[2] = 32'h0000000D; mem[3] = 32'h44444444;
    for (int i = 0; i < 4; i++) ref_mem[i] = mem[i];
    ref_rdata = 32'h0;
    ref_last  = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("reset Mem_rd", 32'(Mem_rd), 32'd1);
    checkOutput("reset Mem_wr", 32'(Mem_wr), 32'd1);
    checkOutput("reset Dir_Mem", Dir_Mem, 32'h0);
    checkOutput("reset Dato_Mem_in", Dato_Mem_in, 32'h0);
    checkOutput("reset rdata", rdata, 32'h0);
    checkOutput("reset acks", {30'd0, ack1, ack0}, 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Run the table, one access per entry.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd, e, nrd, nwr);
      ref_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, erd, eerr);
      checkOutput($sformatf("v%0d latency", i), 32'(lat), 32'd3);
      checkOutput($sformatf("v%0d rdata", i), rd, vecs[i].exp_rdata);
      checkOutput($sformatf("v%0d rd strobes", i), 32'(nrd), vecs[i].we ? 32'd0 : 32'd1);
      checkOutput($sformatf("v%0d wr strobes", i), 32'(nwr), vecs[i].we ? 32'd1 : 32'd0);
      checkOutput($sformatf("v%0d Dir_Mem", i), Dir_Mem, vecs[i].addr);
      if (vecs[i].we) checkOutput($sformatf("v%0d Dato_Mem_in", i), Dato_Mem_in, vecs[i].wdata);
    end

    // Fairness: both ports keep requesting for four accesses.
    for (int k = 0; k < 4; k++) begin
      ref_arbitrate(1'b1, 1'b1, exp_port[k]);
      ref_access(1'b0, exp_port[k] ? BASE + 32'd2 : BASE, 32'h0, exp_rd[k], eerr);
    end
    @(negedge clk);
    drive_port(1'b0, 1'b1, 1'b0, BASE, 32'h0);
    drive_port(1'b1, 1'b1, 1'b0, BASE + 32'd2, 32'h0);
    n = 0; cyc = 0; prev = 0;
    while (n < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ack0 || ack1) begin
        checkOutput($sformatf("fair%0d port", n), 32'(ack1), 32'(exp_port[n]));
        checkOutput($sformatf("fair%0d rdata", n), rdata, exp_rd[n]);
        checkOutput($sformatf("fair%0d spacing", n), 32'(cyc - prev), n == 0 ? 32'd3 : 32'd4);
        prev = cyc;
        n++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    checkOutput("fair ack count", 32'(n), 32'd4);

    // Port 1 raises its request while port 0 is in STROBE.
    ref_access(1'b0, BASE + 32'd1, 32'h0, erd0, eerr);
    ref_access(1'b0, BASE + 32'd3, 32'h0, erd1, eerr);
    @(negedge clk);
    drive_port(1'b0, 1'b1, 1'b0, BASE + 32'd1, 32'h0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("late req Mem_rd in strobe", 32'(Mem_rd), 32'd0);
    drive_port(1'b1, 1'b1, 1'b0, BASE + 32'd3, 32'h0);
    cyc = 2; t0 = -1; t1 = -1;
    while (t1 < 0 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (ack0 && t0 < 0) begin t0 = cyc; checkOutput("late req rdata0", rdata, erd0); req0 = 1'b0; end
      if (ack1 && t1 < 0) begin t1 = cyc; checkOutput("late req rdata1", rdata, erd1); req1 = 1'b0; end
    end
    req0 = 1'b0; req1 = 1'b0;
    checkOutput("late req ack0 time", 32'(t0), 32'd3);
    checkOutput("late req ack1 gap", 32'(t1 - t0), 32'd4);

    // Reset lands in the STROBE cycle of a write.
    @(negedge clk);
    drive_port(1'b0, 1'b1, 1'b1, BASE, 32'h00000099);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst Mem_wr before", 32'(Mem_wr), 32'd0);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst Mem_wr async", 32'(Mem_wr), 32'd1);
    checkOutput("rst Mem_rd async", 32'(Mem_rd), 32'd1);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst ack0", 32'(ack0), 32'd0);
    req0 = 1'b0;
    @(negedge clk);
    checkOutput("rst ack0 held", 32'(ack0), 32'd0);
    rst = 1'b0;
    ref_rdata = 32'h0;
    ref_last  = 1'b1;
    checkOutput("rst write dropped", mem[0], ref_mem[0]);
    applyStimulus(1'b0, 1'b0, BASE, 32'h0, lat, rd, e, nrd, nwr);
    ref_access(1'b0, BASE, 32'h0, erd, eerr);
    checkOutput("post rst latency", 32'(lat), 32'd3);
    checkOutput("post rst rdata", rd, erd);

`ifdef MEM_DATOS_ARB_RANGE_EN
    // Out-of-range read and write: no strobes, normal ack, err pulse.
    applyStimulus(1'b0, 1'b0, BASE + 32'd7, 32'h0, lat, rd, e, nrd, nwr);
    ref_access(1'b0, BASE + 32'd7, 32'h0, erd, eerr);
    checkOutput("oor rd latency", 32'(lat), 32'd3);
    checkOutput("oor rd strobes", 32'(nrd + nwr), 32'd0);
    checkOutput("oor rd err", 32'(e), 32'(eerr));
    checkOutput("oor rd rdata", rd, erd);
    applyStimulus(1'b1, 1'b1, BASE - 32'd1, 32'h55, lat, rd, e, nrd, nwr);
    ref_access(1'b1, BASE - 32'd1, 32'h55, erd, eerr);
    checkOutput("oor wr strobes", 32'(nrd + nwr), 32'd0);
    checkOutput("oor wr err", 32'(e), 32'(eerr));
    checkOutput("oor wr rdata", rd, erd);
`endif

    // Random rounds. Each round has one or two simultaneous requests. Each
    // requester is held until its own ack.
    for (int r = 0; r < 30; r++) begin
      bit          rq [2];
      bit          w [2];
      bit          exp_err [2];
      bit          got_err [2];
      bit          pend [2];
      logic [31:0] a [2];
      logic [31:0] d [2];
      logic [31:0] erdv [2];
      logic [31:0] got_rd [2];
      int          exp_cyc [2];
      int          got_cyc [2];
      bit          first, second;
      rq[0] = 1'($urandom_range(0, 1));
      rq[1] = rq[0] ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int p = 0; p < 2; p++) begin
        w[p] = 1'($urandom_range(0, 1));
        a[p] = BASE + 32'($urandom_range(0, 5));
        d[p] = $urandom();
        got_cyc[p] = -1; got_rd[p] = '0; got_err[p] = 1'b0;
        exp_cyc[p] = 0; erdv[p] = '0; exp_err[p] = 1'b0;
        pend[p] = rq[p];
      end
      ref_arbitrate(rq[0], rq[1], first);
      second = ~first;
      ref_access(w[first], a[first], d[first], erdv[first], exp_err[first]);
      exp_cyc[first] = 3;
      if (rq[0] && rq[1]) begin
        ref_access(w[second], a[second], d[second], erdv[second], exp_err[second]);
        exp_cyc[second] = 7;
      end
      @(negedge clk);
      for (int p = 0; p < 2; p++) if (rq[p]) drive_port(p[0], 1'b1, w[p], a[p], d[p]);
      cyc = 0;
      while ((pend[0] || pend[1]) && cyc < 16) begin
        @(negedge clk);
        cyc++;
        for (int p = 0; p < 2; p++) begin
          if (pend[p] && (p == 1 ? ack1 : ack0)) begin
            got_cyc[p] = cyc; got_rd[p] = rdata; got_err[p] = err_w; pend[p] = 1'b0;
            drive_port(p[0], 1'b0, 1'b0, 32'h0, 32'h0);
          end
        end
      end
      for (int p = 0; p < 2; p++) begin
        drive_port(p[0], 1'b0, 1'b0, 32'h0, 32'h0);
        if (rq[p]) begin
          checkOutput($sformatf("rnd%0d p%0d ack time", r, p), 32'(got_cyc[p]), 32'(exp_cyc[p]));
          checkOutput($sformatf("rnd%0d p%0d rdata", r, p), got_rd[p], erdv[p]);
`ifdef MEM_DATOS_ARB_RANGE_EN
          checkOutput($sformatf("rnd%0d p%0d err", r, p), 32'(got_err[p]), 32'(exp_err[p]));
`endif
        end
      end
    end

    @(negedge clk);
    checkOutput("strobes never both low", 32'(both_low), 32'd0);
    checkOutput("acks never overlap", 32'(ack_both), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop if the run stalls somewhere.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
